// File: rtl/aes_inv_cipher_if.sv
// Handshake bundle for the AES-128 inverse cipher: key load, ciphertext in, plaintext out.
// The core takes the slave side; whoever feeds and drains it takes the master side.
interface aes_inv_cipher_if;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] key_in;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] data_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] data_out;
    logic         busy;

    modport master (
        output key_valid, key_in, in_valid, data_in, out_ready,
        input  key_ready, in_ready, out_valid, data_out, busy
    );

    modport slave (
        input  key_valid, key_in, in_valid, data_in, out_ready,
        output key_ready, in_ready, out_valid, data_out, busy
    );
endinterface

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 inverse cipher: expands the key once to K10, then decrypts one round per
// clock while walking the key schedule backwards from the retained K10.
module aes_inv_cipher #(
    parameter int unsigned Nr = 10
) (
    input logic             clk,
    input logic             rst_n,
    aes_inv_cipher_if.slave bus
);
    localparam logic [3:0] LastRnd = 4'(Nr - 1);

    typedef enum logic [2:0] {StIdle, StKexp, StReady, StRound, StDone} state_e;

    state_e       state_q, state_d;
    logic [127:0] rk_q, rk_d;
    logic [127:0] k_last_q, k_last_d;
    logic [127:0] s_q, s_d;
    logic [3:0]   rcnt_q, rcnt_d;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] acc;
        p   = a;
        acc = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // a^254 is the field inverse and conveniently maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] acc;
        logic [7:0] e;
        e   = 8'hfe;
        p   = a;
        acc = 8'h01;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) acc = gf_mul(acc, p);
            p = gf_mul(p, p);
        end
        return acc;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] a;
        a = gf_inv(x);
        return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]} ^ {a[3:0], a[7:4]}
               ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] y;
        y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(y);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        unique case (idx)
            4'd0:    r = 8'h01;
            4'd1:    r = 8'h02;
            4'd2:    r = 8'h04;
            4'd3:    r = 8'h08;
            4'd4:    r = 8'h10;
            4'd5:    r = 8'h20;
            4'd6:    r = 8'h40;
            4'd7:    r = 8'h80;
            4'd8:    r = 8'h1b;
            4'd9:    r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] imc_coef(input logic [1:0] j);
        logic [7:0] m;
        unique case (j)
            2'd0:    m = 8'h0e;
            2'd1:    m = 8'h0b;
            2'd2:    m = 8'h0d;
            default: m = 8'h09;
        endcase
        return m;
    endfunction

    logic [31:0]  w0, w1, w2, w3, pre_rot, sub_in, sub_out, rcon_w;
    logic [31:0]  f0, f1, f2, f3;
    logic [127:0] kf, kp;

    // The four forward S-boxes serve the forward schedule in KEXP and the inverse one in ROUND.
    always_comb begin : key_sched
        w0      = rk_q[127:96];
        w1      = rk_q[95:64];
        w2      = rk_q[63:32];
        w3      = rk_q[31:0];
        pre_rot = (state_q == StKexp) ? w3 : (w3 ^ w2);
        sub_in  = {pre_rot[23:0], pre_rot[31:24]};
        sub_out = '0;
        for (int i = 0; i < 4; i++) sub_out[8*i +: 8] = sbox(sub_in[8*i +: 8]);
        rcon_w  = {rcon(rcnt_q), 24'h0};
        f0      = w0 ^ sub_out ^ rcon_w;
        f1      = w1 ^ f0;
        f2      = w2 ^ f1;
        f3      = w3 ^ f2;
        kf      = {f0, f1, f2, f3};
        kp      = {w0 ^ sub_out ^ rcon_w, w1 ^ w0, w2 ^ w1, w3 ^ w2};
    end

    logic [127:0] isr, isb, ark, imc;
    logic [7:0]   acc;

    always_comb begin : round_path
        isr = '0;
        imc = '0;
        acc = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                isr[127 - 8*(r + 4*c) -: 8] = s_q[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8];
            end
        end
        isb = '0;
        for (int i = 0; i < 16; i++) isb[8*i +: 8] = inv_sbox(isr[8*i +: 8]);
        ark = isb ^ kp;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) begin
                    acc = acc ^ gf_mul(ark[127 - 8*(k + 4*c) -: 8], imc_coef(2'((k + 4 - r) % 4)));
                end
                imc[127 - 8*(r + 4*c) -: 8] = acc;
            end
        end
    end

    always_comb begin : next_state
        state_d  = state_q;
        rk_d     = rk_q;
        k_last_d = k_last_q;
        s_d      = s_q;
        rcnt_d   = rcnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.key_valid) begin
                    rk_d    = bus.key_in;
                    rcnt_d  = 4'd0;
                    state_d = StKexp;
                end
            end
            StKexp: begin
                rk_d   = kf;
                rcnt_d = rcnt_q + 4'd1;
                if (rcnt_q == LastRnd) begin
                    k_last_d = kf;
                    state_d  = StReady;
                end
            end
            StReady: begin
                if (bus.key_valid) begin
                    rk_d    = bus.key_in;
                    rcnt_d  = 4'd0;
                    state_d = StKexp;
                end else if (bus.in_valid) begin
                    s_d     = bus.data_in ^ k_last_q;
                    rk_d    = k_last_q;
                    rcnt_d  = LastRnd;
                    state_d = StRound;
                end
            end
            StRound: begin
                rk_d   = kp;
                rcnt_d = rcnt_q - 4'd1;
                if (rcnt_q == 4'd0) begin
                    s_d     = ark;
                    state_d = StDone;
                end else begin
                    s_d = imc;
                end
            end
            StDone: begin
                if (bus.out_ready) state_d = StReady;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            rk_q     <= '0;
            k_last_q <= '0;
            s_q      <= '0;
            rcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            rk_q     <= rk_d;
            k_last_q <= k_last_d;
            s_q      <= s_d;
            rcnt_q   <= rcnt_d;
        end
    end

    assign bus.key_ready = (state_q == StIdle) || (state_q == StReady);
    assign bus.in_ready  = (state_q == StReady) && !bus.key_valid;
    assign bus.out_valid = (state_q == StDone);
    assign bus.data_out  = s_q;
    assign bus.busy      = (state_q == StKexp) || (state_q == StRound);
endmodule

// File: tb/tb_aes_inv_cipher.sv
// Directed bench for aes_inv_cipher: FIPS-197 vectors, handshake latencies, backpressure,
// key/block priority and asynchronous abort, checked against a table-based reference model.
module tb_aes_inv_cipher;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    aes_inv_cipher_if bus ();

    aes_inv_cipher dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    localparam logic [127:0] Key1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K10_1 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] Ct1   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] Pt1   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] Key2  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] Ct2   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] Pt2   = 128'h00112233445566778899aabbccddeeff;

    logic [7:0]   sb  [256];
    logic [7:0]   isb [256];
    logic [127:0] model_rk [11];
    logic [127:0] exp_q [$];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %b, want %b", name, got, want);
        end
    endtask

    task automatic chki(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        r = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return r;
    endfunction

    // Walk generator 3 and its inverse together; each pair gives one S-box entry.
    task automatic build_sbox();
        logic [7:0] p;
        logic [7:0] q;
        logic [7:0] x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl(q, 1) ^ rotl(q, 2) ^ rotl(q, 3) ^ rotl(q, 4);
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
        for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
    endtask

    task automatic set_model_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] model_decrypt(input logic [127:0] ct);
        logic [7:0]   st  [16];
        logic [7:0]   tmp [16];
        logic [127:0] v;
        v = ct ^ model_rk[10];
        for (int rnd = 9; rnd >= 0; rnd--) begin
            for (int i = 0; i < 16; i++) st[i] = v[127 - 8*i -: 8];
            // Row r rotates right by r: the byte in column c lands in column c+r.
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) tmp[r + 4*((c + r) % 4)] = isb[st[r + 4*c]];
            for (int i = 0; i < 16; i++) v[127 - 8*i -: 8] = tmp[i];
            v = v ^ model_rk[rnd];
            if (rnd > 0) begin
                for (int i = 0; i < 16; i++) st[i] = v[127 - 8*i -: 8];
                for (int c = 0; c < 4; c++) begin
                    tmp[4*c]   = gmul(st[4*c], 8'h0e) ^ gmul(st[4*c+1], 8'h0b)
                               ^ gmul(st[4*c+2], 8'h0d) ^ gmul(st[4*c+3], 8'h09);
                    tmp[4*c+1] = gmul(st[4*c], 8'h09) ^ gmul(st[4*c+1], 8'h0e)
                               ^ gmul(st[4*c+2], 8'h0b) ^ gmul(st[4*c+3], 8'h0d);
                    tmp[4*c+2] = gmul(st[4*c], 8'h0d) ^ gmul(st[4*c+1], 8'h09)
                               ^ gmul(st[4*c+2], 8'h0e) ^ gmul(st[4*c+3], 8'h0b);
                    tmp[4*c+3] = gmul(st[4*c], 8'h0b) ^ gmul(st[4*c+1], 8'h0d)
                               ^ gmul(st[4*c+2], 8'h09) ^ gmul(st[4*c+3], 8'h0e);
                end
                for (int i = 0; i < 16; i++) v[127 - 8*i -: 8] = tmp[i];
            end
        end
        return v;
    endfunction

    // Output checker: every cycle out_valid is up, data_out must be the oldest pending plaintext.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                chk1("spurious_out_valid", bus.out_valid, 1'b0);
            end else begin
                chk("data_out", bus.data_out, exp_q[0]);
                if (bus.out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic check_reset(input string tag);
        chk1({tag, "_out_valid"}, bus.out_valid, 1'b0);
        chk1({tag, "_in_ready"}, bus.in_ready, 1'b0);
        chk1({tag, "_key_ready"}, bus.key_ready, 1'b1);
        chk1({tag, "_busy"}, bus.busy, 1'b0);
        chk({tag, "_data_out"}, bus.data_out, 128'h0);
    endtask

    task automatic wait_key_done(input string tag);
        int n;
        n = 0;
        while (!bus.key_ready && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        chki({tag, "_kexp_latency"}, n, 10);
        chk1({tag, "_busy_after_kexp"}, bus.busy, 1'b0);
        chk({tag, "_k_last"}, dut.k_last_q, model_rk[10]);
    endtask

    task automatic load_key(input logic [127:0] key, input string tag);
        set_model_key(key);
        chk1({tag, "_key_ready_pre"}, bus.key_ready, 1'b1);
        bus.key_valid = 1'b1;
        bus.key_in    = key;
        @(posedge clk);
        #1;
        bus.key_valid = 1'b0;
        chk1({tag, "_busy_kexp"}, bus.busy, 1'b1);
        chk1({tag, "_in_ready_kexp"}, bus.in_ready, 1'b0);
        wait_key_done(tag);
        chk1({tag, "_in_ready_post"}, bus.in_ready, 1'b1);
    endtask

    // hold == 0 ties out_ready high; otherwise the result is back-pressured for hold cycles.
    task automatic decrypt(input logic [127:0] ct, input int hold, input string tag);
        int n;
        chk1({tag, "_in_ready"}, bus.in_ready, 1'b1);
        exp_q.push_back(model_decrypt(ct));
        bus.out_ready = (hold == 0);
        bus.in_valid  = 1'b1;
        bus.data_in   = ct;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk1({tag, "_busy_round"}, bus.busy, 1'b1);
        n = 0;
        while (!bus.out_valid && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        chki({tag, "_latency"}, n, 10);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk({tag, "_hold_flags"}, {125'h0, bus.out_valid, bus.in_ready, bus.key_ready},
                128'h4);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk1({tag, "_done_released"}, bus.out_valid, 1'b0);
        chk1({tag, "_back_to_ready"}, bus.key_ready, 1'b1);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        bus.key_valid = 1'b0;
        bus.key_in    = '0;
        bus.in_valid  = 1'b0;
        bus.data_in   = '0;
        bus.out_ready = 1'b0;

        build_sbox();
        chk("model_sbox_00", 128'(sb[8'h00]), 128'h63);
        chk("model_sbox_53", 128'(sb[8'h53]), 128'hed);
        chk("model_isbox_16", 128'(isb[8'h16]), 128'hff);
        set_model_key(Key1);
        chk("model_k10", model_rk[10], K10_1);
        chk("model_pt1", model_decrypt(Ct1), Pt1);
        set_model_key(Key2);
        chk("model_pt2", model_decrypt(Ct2), Pt2);

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset("por");
        rst_n = 1'b1;

        load_key(Key1, "k1");
        decrypt(Ct1, 0, "b1");
        chk("b1_plain", bus.data_out, Pt1);

        load_key(Key2, "k2");
        decrypt(Ct2, 20, "b2");
        chk("b2_plain", bus.data_out, Pt2);
        decrypt(Ct2, 0, "b2_again");
        chk("b2_again_plain", bus.data_out, Pt2);

        // Key and block offered together: key wins, block waits for the new schedule.
        set_model_key(Key1);
        bus.key_valid = 1'b1;
        bus.key_in    = Key1;
        bus.in_valid  = 1'b1;
        bus.data_in   = Ct1;
        #1;
        chk1("both_in_ready", bus.in_ready, 1'b0);
        @(posedge clk);
        #1;
        bus.key_valid = 1'b0;
        chk1("both_busy", bus.busy, 1'b1);
        chk1("both_in_ready_kexp", bus.in_ready, 1'b0);
        wait_key_done("both");
        decrypt(Ct1, 3, "both_blk");
        chk("both_plain", bus.data_out, Pt1);

        // Abort in the middle of a decryption.
        bus.in_valid = 1'b1;
        bus.data_in  = Ct1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset("abort");
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        bus.in_valid = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (bus.in_ready || !bus.key_ready || bus.out_valid) n++;
        end
        chki("abort_idle_cycles_wrong", n, 0);
        bus.in_valid = 1'b0;
        load_key(Key1, "k1_again");
        decrypt(Ct1, 0, "b1_after_abort");
        chk("b1_after_abort_plain", bus.data_out, Pt1);

        chki("pending_outputs", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
